// File: rtl/exec_operand_stage_pkg.sv
// Shared types and constants for the execute operand stage.
package exec_operand_stage_pkg;

   // Width of the RV64 word-mode operand before sign extension.
   localparam int unsigned WORD_W = 32;

   // Per-slot operand source select.
   typedef enum logic [2:0] {
      NoSrc        = 3'd0,
      FromImm      = 3'd1,
      FromShamt    = 3'd2,
      FromReg      = 3'd3,
      FromPcAdd4   = 3'd4,
      FromPcAddImm = 3'd5,
      FromCSR      = 3'd6
   } opsrc_t;

endpackage

// File: rtl/exec_operand_stage_if.sv
// Upstream instruction, forwarding and downstream operand bus of the operand stage.
interface exec_operand_stage_if
   import exec_operand_stage_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SHAMT_W = 6
) ();

   logic                           in_valid;
   logic                           in_ready;
   logic [XLEN-1:0]                in_pc;
   logic [XLEN-1:0]                in_imm;
   logic [XLEN-1:0]                in_csr_rdata;
   logic [SHAMT_W-1:0]             in_shamt;
   logic                           in_word;
   opsrc_t [NUM_OPS-1:0]           in_src;
   logic [NUM_OPS-1:0][4:0]        in_rs_idx;
   logic [NUM_OPS-1:0][XLEN-1:0]   in_rs_data;

   logic [NUM_FWD-1:0]             fwd_valid;
   logic [NUM_FWD-1:0]             fwd_pending;
   logic [NUM_FWD-1:0][4:0]        fwd_idx;
   logic [NUM_FWD-1:0][XLEN-1:0]   fwd_data;

   logic                           out_valid;
   logic                           out_ready;
   logic [NUM_OPS-1:0][XLEN-1:0]   out_op;

   // Upstream/forwarding/downstream side.
   modport master (
      output in_valid, in_pc, in_imm, in_csr_rdata, in_shamt, in_word, in_src, in_rs_idx,
             in_rs_data, fwd_valid, fwd_pending, fwd_idx, fwd_data, out_ready,
      input  in_ready, out_valid, out_op
   );

   // Operand stage side.
   modport slave (
      input  in_valid, in_pc, in_imm, in_csr_rdata, in_shamt, in_word, in_src, in_rs_idx,
             in_rs_data, fwd_valid, fwd_pending, fwd_idx, fwd_data, out_ready,
      output in_ready, out_valid, out_op
   );

endinterface

// File: rtl/operand_resolve.sv
// Combinational source selection, forwarding and word narrowing for one operand slot.
module operand_resolve
   import exec_operand_stage_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SHAMT_W = 6
) (
   input  opsrc_t                       src,
   input  logic [4:0]                   rs_idx,
   input  logic [XLEN-1:0]              rs_data,
   input  logic [XLEN-1:0]              pc,
   input  logic [XLEN-1:0]              imm,
   input  logic [XLEN-1:0]              csr_rdata,
   input  logic [SHAMT_W-1:0]           shamt,
   input  logic                         word,
   input  logic [NUM_FWD-1:0]           fwd_valid,
   input  logic [NUM_FWD-1:0]           fwd_pending,
   input  logic [NUM_FWD-1:0][4:0]      fwd_idx,
   input  logic [NUM_FWD-1:0][XLEN-1:0] fwd_data,
   output logic [XLEN-1:0]              value,
   output logic                         hazard
);

   logic [XLEN-1:0] reg_val;
   logic            reg_haz;
   logic [XLEN-1:0] sel;

   // Register resolution: scan oldest to youngest so the youngest match wins.
   always_comb begin
      reg_val = rs_data;
      reg_haz = 1'b0;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_valid[i] && (fwd_idx[i] == rs_idx)) begin
            reg_val = fwd_data[i];
            reg_haz = fwd_pending[i];
         end
      end
      // x0 is hardwired to zero and never forwarded.
      if (rs_idx == 5'd0) begin
         reg_val = '0;
         reg_haz = 1'b0;
      end
   end

   // Source mux, then word-mode sign extension of the low half.
   always_comb begin
      case (src)
         NoSrc:        sel = '0;
         FromImm:      sel = imm;
         FromShamt:    sel = XLEN'(shamt);
         FromReg:      sel = reg_val;
         FromPcAdd4:   sel = pc + XLEN'(4);
         FromPcAddImm: sel = pc + imm;
         FromCSR:      sel = csr_rdata;
         default:      sel = '0;
      endcase
      value  = sel;
      if (word && (src != NoSrc)) begin
         value = XLEN'($signed(sel[WORD_W-1:0]));
      end
      hazard = (src == FromReg) && reg_haz;
   end

endmodule

// File: rtl/exec_operand_stage.sv
// Operand selection/forwarding stage with a one-entry output buffer and stall counter.
module exec_operand_stage
   import exec_operand_stage_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned NUM_FWD = 2,
   parameter int unsigned SHAMT_W = 6,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   exec_operand_stage_if.slave bus,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [0:0] {StEmpty, StFull} buf_state_e;

   buf_state_e                   state_q, state_d;
   logic                         load;
   logic [NUM_OPS-1:0]           slot_haz;
   logic [NUM_OPS-1:0][XLEN-1:0] slot_val;
   logic [NUM_OPS-1:0][XLEN-1:0] op_q;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         hazard;
   logic                         accept;

   for (genvar g = 0; g < NUM_OPS; g++) begin : g_slot
      operand_resolve #(
         .XLEN    (XLEN),
         .NUM_FWD (NUM_FWD),
         .SHAMT_W (SHAMT_W)
      ) u_resolve (
         .src         (bus.in_src[g]),
         .rs_idx      (bus.in_rs_idx[g]),
         .rs_data     (bus.in_rs_data[g]),
         .pc          (bus.in_pc),
         .imm         (bus.in_imm),
         .csr_rdata   (bus.in_csr_rdata),
         .shamt       (bus.in_shamt),
         .word        (bus.in_word),
         .fwd_valid   (bus.fwd_valid),
         .fwd_pending (bus.fwd_pending),
         .fwd_idx     (bus.fwd_idx),
         .fwd_data    (bus.fwd_data),
         .value       (slot_val[g]),
         .hazard      (slot_haz[g])
      );
   end

   // Handshake: stall on load-use, otherwise accept when the buffer frees up.
   always_comb begin
      hazard       = bus.in_valid && (|slot_haz);
      bus.in_ready = !hazard && ((state_q == StEmpty) || bus.out_ready);
      accept       = bus.in_valid && bus.in_ready;
      bus.out_valid = (state_q == StFull);
      bus.out_op    = op_q;
      stall_cnt     = cnt_q;
   end

   // Buffer next state; flush empties the buffer and blocks the load.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d = StFull;
                  load    = 1'b1;
               end
            end
            StFull: begin
               if (accept) begin
                  load = 1'b1;
               end else if (bus.out_ready) begin
                  state_d = StEmpty;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   // Saturating count of cycles spent stalled on a hazard.
   always_comb begin
      cnt_d = cnt_q;
      if (hazard && !flush && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State, operand buffer and counter registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StEmpty;
         op_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load) begin
            op_q <= slot_val;
         end
      end
   end

endmodule

// File: tb/tb_exec_operand_stage.sv
// Scoreboard bench for exec_operand_stage: driver pushes expected operands, monitor pops.
module tb_exec_operand_stage;
   import exec_operand_stage_pkg::*;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned NUM_OPS = 2;
   localparam int unsigned NUM_FWD = 2;
   localparam int unsigned SHAMT_W = 6;
   localparam int unsigned CNT_W   = 3;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             flush;
   logic [CNT_W-1:0] stall_cnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [127:0] exp_q[$];

   exec_operand_stage_if #(
      .XLEN    (XLEN),
      .NUM_OPS (NUM_OPS),
      .NUM_FWD (NUM_FWD),
      .SHAMT_W (SHAMT_W)
   ) bus ();

   exec_operand_stage #(
      .XLEN    (XLEN),
      .NUM_OPS (NUM_OPS),
      .NUM_FWD (NUM_FWD),
      .SHAMT_W (SHAMT_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .bus       (bus),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid     = 1'b0;
      bus.in_pc        = '0;
      bus.in_imm       = '0;
      bus.in_csr_rdata = '0;
      bus.in_shamt     = '0;
      bus.in_word      = 1'b0;
      bus.in_src[0]    = NoSrc;
      bus.in_src[1]    = NoSrc;
      bus.in_rs_idx    = '0;
      bus.in_rs_data   = '0;
      bus.fwd_valid    = '0;
      bus.fwd_pending  = '0;
      bus.fwd_idx      = '0;
      bus.fwd_data     = '0;
   endtask

   // Present the already-set fields, wait (bounded) for in_ready, record expectation.
   task automatic issue(input logic [63:0] e0, input logic [63:0] e1);
      int unsigned waited = 0;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) check("issue_timeout", 64'(bus.in_ready), 64'd1);
      else exp_q.push_back({e1, e0});
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   // Monitor: every consumed output is compared against the oldest expectation.
   always @(negedge clk) begin
      logic [127:0] e;
      if (reset_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_op0", bus.out_op[0], e[63:0]);
            check("out_op1", bus.out_op[1], e[127:64]);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      bus.out_ready = 1'b1;
      flush         = 1'b0;
      reset_n       = 1'b0;
      @(negedge clk);
      check("in_ready_in_reset", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_out_op0", bus.out_op[0], 64'd0);
      check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;

      // PC-relative sources.
      bus.in_pc = 64'h1000; bus.in_imm = 64'h10;
      bus.in_src[0] = FromPcAddImm; bus.in_src[1] = FromPcAdd4;
      issue(64'h1010, 64'h1004);

      // Shift amount and immediate.
      bus.in_shamt = 6'h3F; bus.in_imm = 64'hFFFF_FFFF_FFFF_FFF0;
      bus.in_src[0] = FromShamt; bus.in_src[1] = FromImm;
      issue(64'h3F, 64'hFFFF_FFFF_FFFF_FFF0);

      // Both ports match: youngest wins; slot1 reads CSR.
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd5; bus.in_rs_data[0] = 64'h1234;
      bus.fwd_valid = 2'b11; bus.fwd_idx[0] = 5'd5; bus.fwd_idx[1] = 5'd5;
      bus.fwd_data[0] = 64'hAA; bus.fwd_data[1] = 64'hBB;
      bus.in_src[1] = FromCSR; bus.in_csr_rdata = 64'hC5C5;
      issue(64'hAA, 64'hC5C5);

      // Same, but x0 is never forwarded.
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd0; bus.in_rs_data[0] = 64'h1234;
      bus.fwd_valid = 2'b11; bus.fwd_idx[0] = 5'd0; bus.fwd_idx[1] = 5'd0;
      bus.fwd_data[0] = 64'hAA; bus.fwd_data[1] = 64'hBB;
      bus.in_src[1] = FromCSR; bus.in_csr_rdata = 64'hC5C5;
      issue(64'h0, 64'hC5C5);

      // Only the older port matches slot0; slot1 misses and reads the register file.
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd5;
      bus.in_src[1] = FromReg; bus.in_rs_idx[1] = 5'd7; bus.in_rs_data[1] = 64'h777;
      bus.fwd_valid = 2'b11; bus.fwd_idx[0] = 5'd6; bus.fwd_idx[1] = 5'd5;
      bus.fwd_data[0] = 64'hAA; bus.fwd_data[1] = 64'hBB;
      issue(64'hBB, 64'h777);

      // Load-use: young port pending shadows a ready older port.
      bus.in_valid = 1'b1;
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd5;
      bus.fwd_valid = 2'b11; bus.fwd_idx[0] = 5'd5; bus.fwd_idx[1] = 5'd5;
      bus.fwd_pending = 2'b01; bus.fwd_data[1] = 64'hBB;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(bus.in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      check("stall_cnt_3", 64'(stall_cnt), 64'd3);
      bus.fwd_pending = 2'b00; bus.fwd_data[0] = 64'h55;
      issue(64'h55, 64'h0);
      check("stall_cnt_hold", 64'(stall_cnt), 64'd3);

      // Word mode narrowing.
      bus.in_word = 1'b1;
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd9; bus.in_rs_data[0] = 64'h8000_0001;
      bus.in_src[1] = FromImm; bus.in_imm = 64'h0000_0001_7FFF_FFFF;
      issue(64'hFFFF_FFFF_8000_0001, 64'h7FFF_FFFF);

      // Backpressure, then flush together with out_ready and a new instruction.
      repeat (2) @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_src[0] = FromImm; bus.in_imm = 64'hDEAD;
      issue(64'hDEAD, 64'h0);
      bus.in_valid = 1'b1; bus.in_src[0] = FromImm; bus.in_imm = 64'hBEEF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("bp_in_ready", 64'(bus.in_ready), 64'd0);
         check("bp_out_valid", 64'(bus.out_valid), 64'd1);
         check("bp_out_op0", bus.out_op[0], 64'hDEAD);
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      flush         = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      flush = 1'b0;
      idle_inputs();
      @(negedge clk);
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a stall.
      bus.in_valid = 1'b1;
      bus.in_src[0] = FromReg; bus.in_rs_idx[0] = 5'd5;
      bus.fwd_valid = 2'b01; bus.fwd_idx[0] = 5'd5; bus.fwd_pending = 2'b01;
      repeat (2) @(posedge clk);
      #1;
      check("stall_cnt_5", 64'(stall_cnt), 64'd5);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("midstall_reset_cnt", 64'(stall_cnt), 64'd0);
      check("midstall_reset_valid", 64'(bus.out_valid), 64'd0);

      // Flushed stall cycles are not counted; then saturate.
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_no_count", 64'(stall_cnt), 64'd0);
      repeat (9) @(posedge clk);
      #1;
      check("stall_cnt_sat", 64'(stall_cnt), 64'd7);
      idle_inputs();

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
